pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised PC generator for the single-cycle RISC-V core. It replaces the two-input pc_mux with a PC register and a
//   priority next-PC select (trap, mret, jalr, jal, branch, pc+4). It adds stall hold, redirect capture while stalled, and
//   misaligned-target trapping. It feeds instruction memory and the pc+4 link path of the datapath.
// PARAMETERS
//   XLEN          32             data/address width
//   RESET_VECTOR  32'h0000_0000  PC value after reset
//   TRAP_VECTOR   32'h0000_0100  PC loaded on trap_req or misaligned target
//   ALIGN_BITS    2              low target bits that must be zero (2 = RV32I, 1 = C extension)
// PORTS
//   clk           in   1     clock, rising edge
//   rst           in   1     asynchronous reset, active-high
//   stall         in   1     hold PC this cycle
//   br_taken      in   1     conditional branch taken
//   br_target     in   XLEN  branch target
//   jal_en        in   1     JAL in execute
//   jal_target    in   XLEN  JAL target
//   jalr_en       in   1     JALR in execute
//   jalr_target   in   XLEN  JALR raw target; bit0 is forced to 0 internally
//   trap_req      in   1     synchronous exception/interrupt request
//   mret_en       in   1     return from trap
//   mepc          in   XLEN  trap return address
//   pc            out  XLEN  current PC (registered)
//   pc_plus4      out  XLEN  pc + 4, combinational
//   misalign      out  1     1-cycle pulse: a misaligned target was rejected
//   bad_addr      out  XLEN  last rejected target (registered)
//   pending       out  1     a redirect is held while stalled
// BEHAVIOUR
//   - Reset (async, any time): pc=RESET_VECTOR, bad_addr=0, misalign=0, pending=0, FSM=RUN. Reset clears any held redirect.
//   - Select priority, highest first: trap_req > mret_en > jalr_en > jal_en > br_taken > pc+4.
//     tgt = the highest-priority active target. redir = OR of all request inputs.
//   - Alignment check: a non-trap redirect is misaligned when tgt[ALIGN_BITS-1:0] != 0.
//     On acceptance the next PC is TRAP_VECTOR, bad_addr<=tgt, and misalign is 1 for one cycle.
//     Trap and pc+4 are never checked.
//   - pc+4 and all target arithmetic are modulo 2^XLEN; wrap from 'hFFFF_FFFC to 0 is legal.
//   - FSM RUN (no stall)
//     - redir=1: pc<=tgt (or TRAP_VECTOR if misaligned).
//     - otherwise: pc<=pc+4.
//   - FSM RUN (stall=1)
//     - pc holds.
//     - If redir=1: capture tgt into hold_pc, mark hold_trap for trap or misaligned, set pending=1, go to HOLD.
//   - FSM HOLD (stall=1)
//     - pc holds.
//     - A new trap_req overwrites the capture. Any other new redirect is ignored, because the first one wins.
//   - FSM HOLD (stall=0)
//     - pc<=hold_pc, or TRAP_VECTOR if hold_trap. This happens even if a new redir is present that cycle.
//     - pending<=0; go to RUN.
//     - misalign pulses this cycle if the capture was misaligned.
//   - Update latency is 1 clk. A stall and a redirect in the same cycle are captured, never lost.
// STRUCTURE
//   - Shared package rv_pkg: XLEN, RESET_VECTOR and TRAP_VECTOR defaults, the pc_src_e enum
//     (SRC_SEQ, SRC_BR, SRC_JAL, SRC_JALR, SRC_MRET, SRC_TRAP), and the FSM state enum (ST_RUN, ST_HOLD).
//   - One sub-module, pc_sel_prio: combinational priority encoder plus target mux plus alignment check.
//     Its outputs are tgt, src and mis. The register and FSM stay in pc_gen.
// TESTING
//   1. rst=1 mid-run with pc=0x40 -> pc=0x0 immediately (async); after release, 3 clk -> pc=0x4, 0x8, 0xC.
//   2. pc=0x10, br_taken=1 and jal_en=1 (br_target 0x80, jal_target 0x200) -> next pc=0x200;
//      jalr_target 0x301 (bit0 cleared, so 0x300) -> pc=0x300, misalign=0.
//   3. jal_target=0x102 with ALIGN_BITS=2 -> pc=0x100, misalign high 1 clk, bad_addr=0x102;
//      the same target with ALIGN_BITS=1 -> pc=0x102.
//   4. stall=1 for 3 clk with br_taken (0x80) in clk 1 and jal (0x90) in clk 2 -> pc held, pending=1;
//      on release pc=0x80 and pending=0.
//   5. In HOLD with br 0x80 captured, trap_req in clk 2 -> on release pc=TRAP_VECTOR;
//      rst during HOLD -> pending=0 and pc=RESET_VECTOR, the capture is discarded.
//   6. pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000, pc_plus4=0x4.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: default widths and vectors, PC source
// encoding and the PC generator state machine states.
package rv_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JAL,
    SRC_JALR,
    SRC_MRET,
    SRC_TRAP
  } pc_src_e;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } pc_state_e;

endpackage

// File: rtl/pc_sel_prio.sv
// Next-PC priority select: picks the highest-priority redirect target and
// flags non-trap targets whose low ALIGN_BITS are not zero.
module pc_sel_prio
  import rv_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEFAULT,
  parameter int              ALIGN_BITS  = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic [XLEN-1:0] seq_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_en,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_req,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] tgt,
  output pc_src_e         src,
  output logic            mis
);

  always_comb begin
    tgt = seq_pc;
    src = SRC_SEQ;
    if (trap_req) begin
      tgt = TRAP_VECTOR;
      src = SRC_TRAP;
    end else if (mret_en) begin
      tgt = mepc;
      src = SRC_MRET;
    end else if (jalr_en) begin
      tgt = {jalr_target[XLEN-1:1], 1'b0};
      src = SRC_JALR;
    end else if (jal_en) begin
      tgt = jal_target;
      src = SRC_JAL;
    end else if (br_taken) begin
      tgt = br_target;
      src = SRC_BR;
    end
    // Sequential fetch and the trap vector are trusted, so only real redirects are checked.
    mis = (src != SRC_SEQ) && (src != SRC_TRAP) && (tgt[ALIGN_BITS-1:0] != '0);
  end

endmodule

// File: rtl/pc_gen.sv
// PC register with stall hold, redirect capture while stalled and
// misaligned-target trapping for the single-cycle RISC-V core.
module pc_gen
  import rv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_en,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_req,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic            pending
);

  pc_state_e       state, state_n;
  logic [XLEN-1:0] pc_n, bad_addr_n;
  logic [XLEN-1:0] hold_pc, hold_pc_n;
  logic            hold_trap, hold_trap_n;
  logic            hold_mis, hold_mis_n;
  logic            misalign_n;
  logic [XLEN-1:0] tgt;
  pc_src_e         src;
  logic            mis;
  logic            redir;

  assign pc_plus4 = pc + XLEN'(4);
  assign redir    = (src != SRC_SEQ);
  assign pending  = (state == ST_HOLD);

  pc_sel_prio #(
    .XLEN        (XLEN),
    .ALIGN_BITS  (ALIGN_BITS),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_sel (
    .seq_pc      (pc_plus4),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jal_en      (jal_en),
    .jal_target  (jal_target),
    .jalr_en     (jalr_en),
    .jalr_target (jalr_target),
    .trap_req    (trap_req),
    .mret_en     (mret_en),
    .mepc        (mepc),
    .tgt         (tgt),
    .src         (src),
    .mis         (mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_VECTOR;
      bad_addr  <= '0;
      misalign  <= 1'b0;
      hold_pc   <= '0;
      hold_trap <= 1'b0;
      hold_mis  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      bad_addr  <= bad_addr_n;
      misalign  <= misalign_n;
      hold_pc   <= hold_pc_n;
      hold_trap <= hold_trap_n;
      hold_mis  <= hold_mis_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    bad_addr_n  = bad_addr;
    misalign_n  = 1'b0;
    hold_pc_n   = hold_pc;
    hold_trap_n = hold_trap;
    hold_mis_n  = hold_mis;
    case (state)
      ST_RUN: begin
        if (!stall) begin
          pc_n = mis ? TRAP_VECTOR : tgt;
          if (mis) begin
            misalign_n = 1'b1;
            bad_addr_n = tgt;
          end
        end else if (redir) begin
          hold_pc_n   = tgt;
          hold_trap_n = (src == SRC_TRAP) || mis;
          hold_mis_n  = mis;
          state_n     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The first capture wins; only a trap may replace it while stalled.
        if (stall) begin
          if (trap_req) begin
            hold_pc_n   = TRAP_VECTOR;
            hold_trap_n = 1'b1;
            hold_mis_n  = 1'b0;
          end
        end else begin
          pc_n       = hold_trap ? TRAP_VECTOR : hold_pc;
          misalign_n = hold_mis;
          if (hold_mis) begin
            bad_addr_n = hold_pc;
          end
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic checked
// against a behavioural model, on RV32I and C-extension alignment instances.
module tb_pc_gen;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, jal_en, jalr_en, trap_req, mret_en;
  logic [31:0] br_target, jal_target, jalr_target, mepc;

  logic [31:0] pc_a, pc_plus4_a, bad_addr_a;
  logic        misalign_a, pending_a;
  logic [31:0] pc_b, pc_plus4_b, bad_addr_b;
  logic        misalign_b, pending_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model state, index 0 = ALIGN_BITS 2 instance, index 1 = ALIGN_BITS 1 instance
  logic [31:0] m_pc [2];
  logic [31:0] m_bad_addr [2];
  logic        m_mis [2];
  logic        m_pend [2];
  logic [31:0] m_hold_dest [2];
  logic [31:0] m_hold_addr [2];
  logic        m_hold_bad [2];

  always #5 clk = ~clk;

  pc_gen #(.ALIGN_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jal_en(jal_en), .jal_target(jal_target),
    .jalr_en(jalr_en), .jalr_target(jalr_target),
    .trap_req(trap_req), .mret_en(mret_en), .mepc(mepc),
    .pc(pc_a), .pc_plus4(pc_plus4_a), .misalign(misalign_a),
    .bad_addr(bad_addr_a), .pending(pending_a)
  );

  pc_gen #(.ALIGN_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jal_en(jal_en), .jal_target(jal_target),
    .jalr_en(jalr_en), .jalr_target(jalr_target),
    .trap_req(trap_req), .mret_en(mret_en), .mepc(mepc),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .misalign(misalign_b),
    .bad_addr(bad_addr_b), .pending(pending_b)
  );

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]       = 32'h0;
      m_bad_addr[k] = 32'h0;
      m_mis[k]      = 1'b0;
      m_pend[k]     = 1'b0;
    end
  endfunction

  // One clock of architectural behaviour, using the inputs present at the edge
  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] t;
      logic        has, is_trap, bad;
      int unsigned align;
      align   = (k == 0) ? 4 : 2;
      has     = 1'b1;
      is_trap = 1'b0;
      t       = 32'h0;
      if (trap_req) begin
        t = TRAP;
        is_trap = 1'b1;
      end else if (mret_en) t = mepc;
      else if (jalr_en)     t = jalr_target & ~32'h1;
      else if (jal_en)      t = jal_target;
      else if (br_taken)    t = br_target;
      else                  has = 1'b0;
      bad = has && !is_trap && ((t % align) != 0);
      m_mis[k] = 1'b0;
      if (m_pend[k]) begin
        if (stall) begin
          if (trap_req) begin
            m_hold_dest[k] = TRAP;
            m_hold_bad[k]  = 1'b0;
          end
        end else begin
          m_pc[k]  = m_hold_dest[k];
          m_mis[k] = m_hold_bad[k];
          if (m_hold_bad[k]) m_bad_addr[k] = m_hold_addr[k];
          m_pend[k] = 1'b0;
        end
      end else if (stall) begin
        if (has) begin
          m_pend[k]      = 1'b1;
          m_hold_dest[k] = (is_trap || bad) ? TRAP : t;
          m_hold_bad[k]  = bad;
          m_hold_addr[k] = t;
        end
      end else if (has) begin
        m_pc[k]  = bad ? TRAP : t;
        m_mis[k] = bad;
        if (bad) m_bad_addr[k] = t;
      end else begin
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic clear_inputs();
    stall = 0; br_taken = 0; jal_en = 0; jalr_en = 0; trap_req = 0; mret_en = 0;
    br_target = 0; jal_target = 0; jalr_target = 0; mepc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (pc_a !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc_a, 32'h0); end
    if (pending_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pending got=%b exp=0", pending_a); end
    if (misalign_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign_a); end
    if (bad_addr_a !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_bad_addr got=%h exp=0", bad_addr_a); end
    repeat (16) step();
    vectors++;
    if (pc_a !== 32'h40) begin miscompares++; $display("[TB] FAIL run_to_40 got=%h exp=%h", pc_a, 32'h40); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (pc_a !== 32'h0) begin miscompares++; $display("[TB] FAIL async_reset got=%h exp=%h", pc_a, 32'h0); end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (pc_a !== 32'(4 * i)) begin miscompares++; $display("[TB] FAIL post_reset_seq%0d got=%h exp=%h", i, pc_a, 32'(4 * i)); end
    end
  endtask

  task automatic test_select();
    clear_inputs();
    step();
    vectors++;
    if (pc_a !== 32'h10) begin miscompares++; $display("[TB] FAIL seq_to_10 got=%h exp=%h", pc_a, 32'h10); end
    br_taken = 1; br_target = 32'h80; jal_en = 1; jal_target = 32'h200;
    step();
    vectors++;
    if (pc_a !== 32'h200) begin miscompares++; $display("[TB] FAIL jal_over_br got=%h exp=%h", pc_a, 32'h200); end
    clear_inputs();
    jalr_en = 1; jalr_target = 32'h301;
    step();
    vectors += 3;
    if (pc_a !== 32'h300) begin miscompares++; $display("[TB] FAIL jalr_bit0 got=%h exp=%h", pc_a, 32'h300); end
    if (misalign_a !== 1'b0) begin miscompares++; $display("[TB] FAIL jalr_misalign got=%b exp=0", misalign_a); end
    if (pc_b !== 32'h300) begin miscompares++; $display("[TB] FAIL jalr_bit0_c got=%h exp=%h", pc_b, 32'h300); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    clear_inputs();
    jal_en = 1; jal_target = 32'h102;
    step();
    vectors += 5;
    if (pc_a !== TRAP) begin miscompares++; $display("[TB] FAIL mis_pc got=%h exp=%h", pc_a, TRAP); end
    if (misalign_a !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_pulse got=%b exp=1", misalign_a); end
    if (bad_addr_a !== 32'h102) begin miscompares++; $display("[TB] FAIL mis_bad_addr got=%h exp=%h", bad_addr_a, 32'h102); end
    if (pc_b !== 32'h102) begin miscompares++; $display("[TB] FAIL c_ext_pc got=%h exp=%h", pc_b, 32'h102); end
    if (misalign_b !== 1'b0) begin miscompares++; $display("[TB] FAIL c_ext_misalign got=%b exp=0", misalign_b); end
    clear_inputs();
    step();
    vectors += 3;
    if (misalign_a !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_one_cycle got=%b exp=0", misalign_a); end
    if (pc_a !== 32'h104) begin miscompares++; $display("[TB] FAIL mis_after got=%h exp=%h", pc_a, 32'h104); end
    if (bad_addr_a !== 32'h102) begin miscompares++; $display("[TB] FAIL bad_addr_kept got=%h exp=%h", bad_addr_a, 32'h102); end
  endtask

  task automatic test_stall_capture();
    logic [31:0] held;
    clear_inputs();
    held = pc_a;
    for (int c = 1; c <= 3; c++) begin
      clear_inputs();
      stall = 1;
      if (c == 1) begin br_taken = 1; br_target = 32'h80; end
      if (c == 2) begin jal_en = 1; jal_target = 32'h90; end
      step();
      vectors += 2;
      if (pc_a !== held) begin miscompares++; $display("[TB] FAIL stall_hold%0d got=%h exp=%h", c, pc_a, held); end
      if (pending_a !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_pending%0d got=%b exp=1", c, pending_a); end
    end
    clear_inputs();
    step();
    vectors += 3;
    if (pc_a !== 32'h80) begin miscompares++; $display("[TB] FAIL release_pc got=%h exp=%h", pc_a, 32'h80); end
    if (pending_a !== 1'b0) begin miscompares++; $display("[TB] FAIL release_pending got=%b exp=0", pending_a); end
    if (pc_b !== 32'h80) begin miscompares++; $display("[TB] FAIL release_pc_c got=%h exp=%h", pc_b, 32'h80); end
  endtask

  task automatic test_trap_override();
    clear_inputs();
    stall = 1; br_taken = 1; br_target = 32'h80;
    step();
    clear_inputs();
    stall = 1; trap_req = 1;
    step();
    clear_inputs();
    step();
    vectors++;
    if (pc_a !== TRAP) begin miscompares++; $display("[TB] FAIL hold_trap got=%h exp=%h", pc_a, TRAP); end
    stall = 1; br_taken = 1; br_target = 32'h80;
    step();
    vectors++;
    if (pending_a !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_entry got=%b exp=1", pending_a); end
    #2 rst = 1'b1;
    #1;
    vectors += 2;
    if (pending_a !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_hold_pending got=%b exp=0", pending_a); end
    if (pc_a !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_in_hold_pc got=%h exp=0", pc_a); end
    #1 rst = 1'b0;
    model_reset();
    clear_inputs();
    step();
    vectors++;
    if (pc_a !== 32'h4) begin miscompares++; $display("[TB] FAIL capture_discarded got=%h exp=%h", pc_a, 32'h4); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    jal_en = 1; jal_target = 32'hFFFF_FFFC;
    step();
    vectors += 2;
    if (pc_a !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_setup got=%h exp=FFFFFFFC", pc_a); end
    if (pc_plus4_a !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_plus4_top got=%h exp=0", pc_plus4_a); end
    clear_inputs();
    step();
    vectors += 2;
    if (pc_a !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_pc got=%h exp=0", pc_a); end
    if (pc_plus4_a !== 32'h4) begin miscompares++; $display("[TB] FAIL wrap_plus4 got=%h exp=4", pc_plus4_a); end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      stall       = ($urandom_range(0, 99) < 30);
      trap_req    = ($urandom_range(0, 99) < 5);
      mret_en     = ($urandom_range(0, 99) < 8);
      jalr_en     = ($urandom_range(0, 99) < 10);
      jal_en      = ($urandom_range(0, 99) < 10);
      br_taken    = ($urandom_range(0, 99) < 15);
      br_target   = rand_tgt();
      jal_target  = rand_tgt();
      jalr_target = rand_tgt();
      mepc        = rand_tgt();
      step();
      vectors += 10;
      if (pc_a !== m_pc[0]) begin miscompares++; $display("[TB] FAIL rnd%0d pc_a got=%h exp=%h", n, pc_a, m_pc[0]); end
      if (pc_plus4_a !== m_pc[0] + 32'd4) begin miscompares++; $display("[TB] FAIL rnd%0d pc_plus4_a got=%h exp=%h", n, pc_plus4_a, m_pc[0] + 32'd4); end
      if (misalign_a !== m_mis[0]) begin miscompares++; $display("[TB] FAIL rnd%0d misalign_a got=%b exp=%b", n, misalign_a, m_mis[0]); end
      if (bad_addr_a !== m_bad_addr[0]) begin miscompares++; $display("[TB] FAIL rnd%0d bad_addr_a got=%h exp=%h", n, bad_addr_a, m_bad_addr[0]); end
      if (pending_a !== m_pend[0]) begin miscompares++; $display("[TB] FAIL rnd%0d pending_a got=%b exp=%b", n, pending_a, m_pend[0]); end
      if (pc_b !== m_pc[1]) begin miscompares++; $display("[TB] FAIL rnd%0d pc_b got=%h exp=%h", n, pc_b, m_pc[1]); end
      if (pc_plus4_b !== m_pc[1] + 32'd4) begin miscompares++; $display("[TB] FAIL rnd%0d pc_plus4_b got=%h exp=%h", n, pc_plus4_b, m_pc[1] + 32'd4); end
      if (misalign_b !== m_mis[1]) begin miscompares++; $display("[TB] FAIL rnd%0d misalign_b got=%b exp=%b", n, misalign_b, m_mis[1]); end
      if (bad_addr_b !== m_bad_addr[1]) begin miscompares++; $display("[TB] FAIL rnd%0d bad_addr_b got=%h exp=%h", n, bad_addr_b, m_bad_addr[1]); end
      if (pending_b !== m_pend[1]) begin miscompares++; $display("[TB] FAIL rnd%0d pending_b got=%b exp=%b", n, pending_b, m_pend[1]); end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_select();
    test_misalign();
    test_stall_capture();
    test_trap_override();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
